// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART packet controller and alu32.
package uart_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_DIV = 2'd2
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_ISSUE,
    ST_WAIT,
    ST_TX,
    ST_DRAIN
  } state_e;

  localparam int unsigned HDR_LEN   = 4;
  localparam int unsigned OPERAND_W = 32;

endpackage

// File: rtl/byte_serializer.sv
// Loads a 64-bit word and emits its low 4 or 8 bytes LSB first over valid/ready.
module byte_serializer (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic        len8_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [63:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;

  assign tx_valid_o = (cnt_q != 4'd0);
  assign tx_data_o  = shift_q[7:0];
  assign done_o     = tx_valid_o & tx_ready_i & (cnt_q == 4'd1);

  // Load a new word, or shift out one byte per accepted transfer.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = len8_i ? 4'd8 : 4'd4;
    end else if (tx_valid_o && tx_ready_i) begin
      shift_d = {8'h00, shift_q[63:8]};
      cnt_d   = cnt_q - 4'd1;
    end
  end

  // Shift register and remaining-byte counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Parses command packets from the RX byte stream, sequences alu32 operations
// (feeding the running result back as operand A) and returns the result on TX.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter logic [7:0] OpAddByte = 8'hA0,
  parameter logic [7:0] OpMulByte = 8'hB2,
  parameter logic [7:0] OpDivByte = 8'hD1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  output logic [1:0]  alu_opcode_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  input  logic [63:0] alu_result_i,
  input  logic        alu_valid_i,
  output logic        alu_ready_o
);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  hdr_op_q, hdr_op_d;
  logic [7:0]  len_lo_q, len_lo_d;
  opcode_e     op_q, op_d;
  logic [13:0] rem_q, rem_d;
  logic [15:0] drain_q, drain_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;

  logic        rx_fire;
  logic [15:0] len_w;
  logic        hdr_known;
  opcode_e     hdr_opcode;
  logic        hdr_ok;
  logic        ser_load;
  logic        ser_done;

  // Reset gating keeps rx_ready_o low for the whole time reset is held.
  assign rx_ready_o = reset_ni & (state_q inside {ST_HDR, ST_LOAD_A, ST_LOAD_B, ST_DRAIN});
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign len_w      = {rx_data_i, len_lo_q};

  assign alu_valid_o     = (state_q == ST_ISSUE);
  assign alu_ready_o     = (state_q == ST_WAIT);
  assign alu_opcode_o    = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;

  // Map the packet opcode byte onto the ALU opcode.
  always_comb begin
    hdr_known  = 1'b1;
    hdr_opcode = OP_ADD;
    if (hdr_op_q == OpAddByte) begin
      hdr_opcode = OP_ADD;
    end else if (hdr_op_q == OpMulByte) begin
      hdr_opcode = OP_MUL;
    end else if (hdr_op_q == OpDivByte) begin
      hdr_opcode = OP_DIV;
    end else begin
      hdr_known = 1'b0;
    end
    hdr_ok = hdr_known && (len_w >= 16'd12) && (len_w[1:0] == 2'b00)
             && ((hdr_opcode != OP_DIV) || (len_w == 16'd12));
  end

  // Packet sequencing: next state, operand assembly and result hand-off.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_op_d   = hdr_op_q;
    len_lo_d   = len_lo_q;
    op_d       = op_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    a_d        = a_q;
    b_d        = b_q;
    ser_load   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: hdr_op_d = rx_data_i;
            2'd2: len_lo_d = rx_data_i;
            2'd3: begin
              if (hdr_ok) begin
                op_d    = hdr_opcode;
                // Number of B operands still to come after A.
                rem_d   = len_w[15:2] - 14'd2;
                state_d = ST_LOAD_A;
              end else if (len_w > 16'(HDR_LEN)) begin
                drain_d = len_w - 16'(HDR_LEN);
                state_d = ST_DRAIN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD_A: begin
        if (rx_fire) begin
          a_d        = {rx_data_i, a_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (rx_fire) begin
          b_d        = {rx_data_i, b_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (alu_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_valid_i) begin
          if (rem_q > 14'd1) begin
            rem_d   = rem_q - 14'd1;
            a_d     = alu_result_i[31:0];
            state_d = ST_LOAD_B;
          end else begin
            ser_load = 1'b1;
            state_d  = ST_TX;
          end
        end
      end
      ST_TX: begin
        if (ser_done) state_d = ST_HDR;
      end
      ST_DRAIN: begin
        if (rx_fire) begin
          drain_d = drain_q - 16'd1;
          if (drain_q == 16'd1) state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_HDR;
      byte_cnt_q <= '0;
      hdr_op_q   <= '0;
      len_lo_q   <= '0;
      op_q       <= OP_ADD;
      rem_q      <= '0;
      drain_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_op_q   <= hdr_op_d;
      len_lo_q   <= len_lo_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  byte_serializer u_ser (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (ser_load),
    .data_i     (alu_result_i),
    .len8_i     (op_q == OP_DIV),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (ser_done)
  );

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with a behavioural alu32 responder.
module tb_uart_alu_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [1:0]  alu_opcode_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic [63:0] alu_result_i;
  logic        alu_valid_i;
  logic        alu_ready_o;

  always #5 clk_i = ~clk_i;

  uart_alu_ctrl #(
    .OpAddByte(8'hA0),
    .OpMulByte(8'hB2),
    .OpDivByte(8'hD1)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .alu_valid_o     (alu_valid_o),
    .alu_ready_i     (alu_ready_i),
    .alu_opcode_o    (alu_opcode_o),
    .alu_operand_a_o (alu_operand_a_o),
    .alu_operand_b_o (alu_operand_b_o),
    .alu_result_i    (alu_result_i),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  alu_req_t    exp_req_q[$];
  logic [7:0]  exp_tx_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned hold_cycles = 0;
  bit          slow_alu = 1'b0;
  bit          tx_always_ready = 1'b1;
  bit          rx_gaps = 1'b0;

  task automatic check_eq(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_word(input int v);
    logic [31:0] w;
    w = v;
    for (int k = 0; k < 4; k++) exp_tx_q.push_back(w[8*k +: 8]);
  endfunction

  function automatic void model_packet(input logic [7:0] opb, input int unsigned len,
                                       input int ops[$], input bit expect_tx);
    bit       valid;
    int       acc;
    alu_req_t r;
    valid = (opb == 8'hA0 || opb == 8'hB2 || opb == 8'hD1) && len >= 12 && (len % 4) == 0
            && (opb != 8'hD1 || len == 12);
    if (!valid) return;
    if (opb == 8'hD1) begin
      r = '{op: 2'd2, a: ops[0], b: ops[1]};
      exp_req_q.push_back(r);
      if (expect_tx) begin
        push_word(ops[0] / ops[1]);
        push_word(ops[0] % ops[1]);
      end
      return;
    end
    acc = ops[0];
    for (int i = 1; i < ops.size(); i++) begin
      r = '{op: (opb == 8'hA0) ? 2'd0 : 2'd1, a: acc, b: ops[i]};
      exp_req_q.push_back(r);
      acc = (opb == 8'hA0) ? acc + ops[i] : acc * ops[i];
    end
    if (expect_tx) push_word(acc);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int t;
    if (rx_gaps && $urandom_range(0, 3) == 0) begin
      rx_valid_i = 1'b0;
      @(negedge clk_i);
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    t = 0;
    while (!rx_ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 2000) check_eq("rx_accept_timeout", 96'(t), 96'(0));
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] opb, input int unsigned len,
                             input int ops[$], input bit expect_tx);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [15:0] l16;
    int unsigned npay;
    model_packet(opb, len, ops, expect_tx);
    l16 = len[15:0];
    bytes.push_back(opb);
    bytes.push_back(8'($urandom));
    bytes.push_back(l16[7:0]);
    bytes.push_back(l16[15:8]);
    npay = (len > 4) ? len - 4 : 0;
    for (int unsigned k = 0; k < npay; k++) begin
      if (k / 4 < ops.size()) begin
        w = ops[k/4];
        bytes.push_back(w[8*(k%4) +: 8]);
      end else begin
        bytes.push_back(8'($urandom));
      end
    end
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic check_reset_outputs();
    check_eq("reset_ctrl_outs",
             {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_ready_o, alu_opcode_o},
             '0);
    check_eq("reset_operands", {alu_operand_a_o, alu_operand_b_o}, '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    @(negedge clk_i);
    check_reset_outputs();
    @(negedge clk_i);
    #2 reset_ni = 1'b1;
    @(negedge clk_i);
    check_eq("rx_ready_after_reset", 96'(rx_ready_o), 96'(1));
  endtask

  // ---------------- alu32 responder + request monitor ----------------
  initial begin : alu_model
    bit          busy;
    int unsigned lat;
    logic [63:0] res;
    bit          stall;
    logic [65:0] stall_fields;
    alu_req_t    r;
    int          sa, sb;
    busy = 0; lat = 0; res = '0; stall = 0; stall_fields = '0;
    alu_valid_i  = 1'b0;
    alu_ready_i  = 1'b0;
    alu_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        busy = 0; stall = 0;
        alu_valid_i = 1'b0;
        alu_ready_i = 1'b0;
        continue;
      end
      if (stall)
        check_eq("alu_hold", {alu_valid_o, alu_opcode_o, alu_operand_a_o, alu_operand_b_o},
                 {1'b1, stall_fields});
      stall = 0;
      if (!busy) begin
        alu_valid_i = 1'b0;
        if (alu_valid_o && hold_cycles > 0) begin
          alu_ready_i = 1'b0;
          hold_cycles--;
        end else begin
          alu_ready_i = ($urandom_range(0, 2) != 0);
        end
        if (alu_valid_o && !alu_ready_i) begin
          stall = 1;
          stall_fields = {alu_opcode_o, alu_operand_a_o, alu_operand_b_o};
        end
        if (alu_valid_o && alu_ready_i) begin
          if (exp_req_q.size() == 0) begin
            check_eq("alu_unexpected_req", {alu_opcode_o, alu_operand_a_o, alu_operand_b_o}, '0);
          end else begin
            r = exp_req_q.pop_front();
            check_eq("alu_req", {alu_opcode_o, alu_operand_a_o, alu_operand_b_o}, {r.op, r.a, r.b});
          end
          sa = alu_operand_a_o;
          sb = alu_operand_b_o;
          case (alu_opcode_o)
            2'd0: res = 64'(longint'(sa + sb));
            2'd1: res = 64'(longint'(sa) * longint'(sb));
            default: begin
              if (sb == 0 || (sa == int'(32'h8000_0000) && sb == -1)) res = '0;
              else res = {32'(sa % sb), 32'(sa / sb)};
            end
          endcase
          busy = 1;
          lat  = slow_alu ? 12 : $urandom_range(0, 3);
        end
      end else begin
        alu_ready_i = 1'b0;
        if (lat > 0) begin
          lat--;
          alu_valid_i = 1'b0;
        end else begin
          alu_valid_i  = 1'b1;
          alu_result_i = res;
          if (alu_ready_o) busy = 0;
        end
      end
    end
  end

  // ---------------- TX sink + byte monitor ----------------
  initial begin : tx_monitor
    bit         stall;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall = 0; stall_data = '0;
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        stall = 0;
        tx_ready_i = 1'b0;
        continue;
      end
      if (stall) check_eq("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, stall_data});
      tx_ready_i = tx_always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_tx_q.size() == 0) begin
          check_eq("tx_unexpected_byte", 96'(tx_data_o), '0);
        end else begin
          e = exp_tx_q.pop_front();
          check_eq("tx_byte", 96'(tx_data_o), 96'(e));
        end
      end
      stall = tx_valid_o && !tx_ready_i;
      stall_data = tx_data_o;
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  // ---------------- main stimulus ----------------
  initial begin : stimulus
    int          t;
    int          ops[$];
    logic [7:0]  opb;
    int unsigned kind, n, len;
    reset_ni   = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs();
    #2 reset_ni = 1'b1;
    @(negedge clk_i);
    check_eq("rx_ready_after_reset", 96'(rx_ready_o), 96'(1));

    // Directed packets
    send_packet(8'hA0, 12, '{5, 7}, 1);
    send_packet(8'hA0, 16, '{1, 2, 3}, 1);
    hold_cycles = 5;
    send_packet(8'hB2, 12, '{-3, 4}, 1);
    send_packet(8'hD1, 12, '{100, 7}, 1);
    send_packet(8'h55, 12, '{32'h1111_2222, 32'h3333_4444}, 1);
    send_packet(8'hA0, 12, '{-10, 3}, 1);
    send_packet(8'hD1, 16, '{9, 3, 1}, 1);
    send_packet(8'hA0, 12, '{32'h7FFF_FFFF, 1}, 1);
    send_packet(8'hA0, 2, '{}, 1);
    send_packet(8'hB2, 12, '{6, 7}, 1);

    // Reset during LOAD_B: partial packet lost
    foreach (ops[i]) ops.delete(i);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00);
    pulse_reset();
    send_packet(8'hA0, 12, '{20, 22}, 1);

    // Reset during WAIT: issued request seen, result discarded, no TX
    slow_alu = 1'b1;
    send_packet(8'hB2, 12, '{9, 9}, 0);
    t = 0;
    while (!alu_ready_o && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 500) check_eq("wait_state_timeout", 96'(t), 96'(0));
    pulse_reset();
    slow_alu = 1'b0;
    send_packet(8'hD1, 12, '{-100, 7}, 1);

    // Randomized traffic with TX backpressure and RX gaps
    tx_always_ready = 1'b0;
    rx_gaps = 1'b1;
    for (int p = 0; p < 30; p++) begin
      ops = {};
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin opb = 8'hA0; n = $urandom_range(2, 5); len = 4 + 4 * n; end
        1: begin opb = 8'hB2; n = $urandom_range(2, 5); len = 4 + 4 * n; end
        2: begin opb = 8'hD1; n = 2; len = 12; end
        3: begin opb = 8'($urandom_range(0, 8'h9F)); n = $urandom_range(0, 3); len = 4 + 4 * n; end
        4: begin opb = 8'hA0; len = $urandom_range(0, 19); n = (len > 4) ? (len - 4) / 4 : 0; end
        default: begin opb = 8'hD1; len = 4 * $urandom_range(4, 5); n = (len - 4) / 4; end
      endcase
      for (int unsigned k = 0; k < n; k++) ops.push_back(int'($urandom));
      if (opb == 8'hD1 && n >= 2) begin
        if ($urandom_range(0, 1) == 0) ops[1] = int'($urandom_range(1, 50)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
        if (ops[1] == 0) ops[1] = 1;
        if (ops[0] == int'(32'h8000_0000) && ops[1] == -1) ops[1] = 1;
      end
      send_packet(opb, len, ops, 1);
    end

    t = 0;
    while ((exp_tx_q.size() != 0 || exp_req_q.size() != 0) && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    repeat (20) @(negedge clk_i);
    check_eq("tx_queue_drained", 96'(exp_tx_q.size()), 96'(0));
    check_eq("alu_queue_drained", 96'(exp_req_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
